// File: rtl/pool_stream_writer_if.sv
// Pixel stream input and result-bank write port of the pool stream writer.
// The writer block itself connects through the slave modport.
interface pool_stream_writer_if #(
  parameter int DW = 19,
  parameter int AW = 12
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          wr;
  logic [AW-1:0] waddr;
  logic [DW:0]   wdata;
  logic [2:0]    wsel;

  modport master (
    output in_valid, in_data,
    input  in_ready, wr, waddr, wdata, wsel
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, wr, waddr, wdata, wsel
  );
endinterface

// File: rtl/pool_stream_writer.sv
// Writes a raster, channel-interleaved pixel stream to the layer-0 bank and
// its 2x2 max / rounded-average pooled result to the layer-1 bank.
module pool_stream_writer #(
  parameter int DW    = 19,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int CH    = 2,
  parameter int AW    = 12
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic mode,
  output logic busy,
  output logic done,
  pool_stream_writer_if.slave bus
);
  // state  | meaning
  // IDLE   | waiting for start
  // RUN    | accepting pixels, raw writes
  // POOLWR | input stalled, pooled write being issued
  // FLUSH  | last pooled write on the port, done next
  typedef enum logic [1:0] {IDLE, RUN, POOLWR, FLUSH} state_t;

  localparam int KW = (CH > 1) ? $clog2(CH) : 1;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int HW = (IMG_W > 2) ? $clog2(IMG_W / 2) : 1;
  localparam logic [AW-1:0] ROW_STRIDE  = AW'(IMG_W);
  localparam logic [AW-1:0] POOL_STRIDE = AW'(IMG_W / 2);

  state_t state, state_next;
  logic          ready, accept;
  logic [KW-1:0] k_cnt;
  logic [CW-1:0] c_cnt;
  logic [RW-1:0] r_cnt;
  logic [HW-1:0] c_half;
  logic          mode_q, last_q, done_q, wr_q;
  logic [AW-1:0] waddr_q, pool_addr_q, raw_addr, pool_addr;
  logic [DW:0]   wdata_q;
  logic [2:0]    wsel_q, pool_sel_q;
  logic [DW-1:0] pool_res_q, pool_val;
  logic [DW+1:0] px_ext, hold_comb, part_comb, pool_sum;
  logic          blk_end, frame_last;
  logic          unused_bits;

  logic [DW+1:0] hold [1 << KW];
  logic [DW+1:0] part [1 << HW][1 << KW];

  function automatic logic [DW+1:0] combine(input logic [DW+1:0] a,
                                            input logic [DW+1:0] b,
                                            input logic avg);
    logic [DW+1:0] res;
    if (avg) res = a + b;
    else     res = (a > b) ? a : b;
    return res;
  endfunction

  assign c_half     = HW'(c_cnt >> 1);
  assign px_ext     = {2'b00, bus.in_data};
  assign hold_comb  = combine(hold[k_cnt], px_ext, mode_q);
  assign part_comb  = combine(part[c_half][k_cnt], px_ext, mode_q);
  // Round half up: four-pixel sum plus two, then divide by four.
  assign pool_sum   = hold_comb + {{DW{1'b0}}, 2'b10};
  assign pool_val   = mode_q ? pool_sum[DW+1:2] : hold_comb[DW-1:0];
  assign blk_end    = r_cnt[0] & c_cnt[0];
  assign frame_last = (r_cnt == RW'(IMG_H - 1)) && (c_cnt == CW'(IMG_W - 1)) &&
                      (k_cnt == KW'(CH - 1));
  assign raw_addr   = AW'(r_cnt) * ROW_STRIDE + AW'(c_cnt);
  assign pool_addr  = AW'(r_cnt >> 1) * POOL_STRIDE + AW'(c_cnt >> 1);
  assign unused_bits = ^{pool_sum[1:0], hold_comb[DW+1:DW]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    accept     = 1'b0;
    unique case (state)
      IDLE:   if (start && !done_q) state_next = RUN;
      RUN: begin
        ready  = 1'b1;
        accept = bus.in_valid;
        if (accept && blk_end) state_next = POOLWR;
      end
      POOLWR: state_next = last_q ? FLUSH : RUN;
      FLUSH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_cnt       <= '0;
      c_cnt       <= '0;
      r_cnt       <= '0;
      mode_q      <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      wsel_q      <= '0;
      pool_addr_q <= '0;
      pool_sel_q  <= '0;
      pool_res_q  <= '0;
      for (int k = 0; k < (1 << KW); k++) hold[k] <= '0;
      for (int i = 0; i < (1 << HW); i++)
        for (int k = 0; k < (1 << KW); k++) part[i][k] <= '0;
    end else begin
      wr_q   <= 1'b0;
      done_q <= (state == FLUSH);
      if (state == IDLE && start && !done_q) begin
        k_cnt  <= '0;
        c_cnt  <= '0;
        r_cnt  <= '0;
        mode_q <= mode;
        last_q <= 1'b0;
      end
      if (accept) begin
        wr_q    <= 1'b1;
        waddr_q <= raw_addr;
        wdata_q <= {1'b0, bus.in_data};
        wsel_q  <= 3'd1 + 3'(k_cnt);
        unique case ({r_cnt[0], c_cnt[0]})
          2'b00: hold[k_cnt]         <= px_ext;
          2'b01: part[c_half][k_cnt] <= hold_comb;
          2'b10: hold[k_cnt]         <= part_comb;
          default: begin
            pool_res_q  <= pool_val;
            pool_addr_q <= pool_addr;
            pool_sel_q  <= 3'(CH + 1) + 3'(k_cnt);
            last_q      <= frame_last;
          end
        endcase
        if (k_cnt == KW'(CH - 1)) begin
          k_cnt <= '0;
          if (c_cnt == CW'(IMG_W - 1)) begin
            c_cnt <= '0;
            r_cnt <= (r_cnt == RW'(IMG_H - 1)) ? '0 : r_cnt + 1'b1;
          end else begin
            c_cnt <= c_cnt + 1'b1;
          end
        end else begin
          k_cnt <= k_cnt + 1'b1;
        end
      end
      if (state == POOLWR) begin
        wr_q    <= 1'b1;
        waddr_q <= pool_addr_q;
        wdata_q <= {1'b0, pool_res_q};
        wsel_q  <= pool_sel_q;
      end
    end
  end

  assign busy         = (state != IDLE) | done_q;
  assign done         = done_q;
  assign bus.in_ready = ready;
  assign bus.wr       = wr_q;
  assign bus.waddr    = waddr_q;
  assign bus.wdata    = wdata_q;
  assign bus.wsel     = wsel_q;
endmodule

// File: tb/tb_pool_stream_writer.sv
// Bench for pool_stream_writer: three geometries share one driver and one
// write monitor, checked against a frame-level pooling reference model.
module tb_pool_stream_writer;
  localparam int DW = 19;
  localparam int AW = 12;

  typedef struct packed {
    logic [2:0]    sel;
    logic [AW-1:0] addr;
    logic [DW:0]   data;
  } wr_t;

  typedef struct {
    int a, b, c, d;
    bit md;
    int exp;
  } blk_vec_t;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, mode = 1'b0, in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  int sel = 0, gw = 4, gh = 4, gch = 1;
  int tests = 0, fails = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, last_wr_cyc = 0;
  logic [DW-1:0] frame [64 * 64 * 3];
  wr_t exp_q[$], cap_q[$];
  blk_vec_t tbl[8];

  pool_stream_writer_if #(.DW(DW), .AW(AW)) b0 ();
  pool_stream_writer_if #(.DW(DW), .AW(AW)) b1 ();
  pool_stream_writer_if #(.DW(DW), .AW(AW)) b2 ();
  logic busy0, busy1, busy2, done0, done1, done2;
  logic m_busy, m_done, m_in_ready, m_wr;
  logic [AW-1:0] m_waddr;
  logic [DW:0] m_wdata;
  logic [2:0] m_wsel;

  assign b0.in_valid = in_valid && (sel == 0);
  assign b1.in_valid = in_valid && (sel == 1);
  assign b2.in_valid = in_valid && (sel == 2);
  assign b0.in_data  = in_data;
  assign b1.in_data  = in_data;
  assign b2.in_data  = in_data;

  pool_stream_writer #(.DW(DW), .IMG_W(4), .IMG_H(4), .CH(1), .AW(AW)) dut0 (
    .clk(clk), .reset(reset), .start(start && (sel == 0)), .mode(mode),
    .busy(busy0), .done(done0), .bus(b0));
  pool_stream_writer #(.DW(DW), .IMG_W(4), .IMG_H(4), .CH(2), .AW(AW)) dut1 (
    .clk(clk), .reset(reset), .start(start && (sel == 1)), .mode(mode),
    .busy(busy1), .done(done1), .bus(b1));
  pool_stream_writer #(.DW(DW), .IMG_W(64), .IMG_H(64), .CH(2), .AW(AW)) dut2 (
    .clk(clk), .reset(reset), .start(start && (sel == 2)), .mode(mode),
    .busy(busy2), .done(done2), .bus(b2));

  assign m_busy     = (sel == 0) ? busy0       : (sel == 1) ? busy1       : busy2;
  assign m_done     = (sel == 0) ? done0       : (sel == 1) ? done1       : done2;
  assign m_in_ready = (sel == 0) ? b0.in_ready : (sel == 1) ? b1.in_ready : b2.in_ready;
  assign m_wr       = (sel == 0) ? b0.wr       : (sel == 1) ? b1.wr       : b2.wr;
  assign m_waddr    = (sel == 0) ? b0.waddr    : (sel == 1) ? b1.waddr    : b2.waddr;
  assign m_wdata    = (sel == 0) ? b0.wdata    : (sel == 1) ? b1.wdata    : b2.wdata;
  assign m_wsel     = (sel == 0) ? b0.wsel     : (sel == 1) ? b1.wsel     : b2.wsel;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (m_wr) begin
        cap_q.push_back({m_wsel, m_waddr, m_wdata});
        last_wr_cyc = cyc;
      end
      if (m_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  initial begin
    #50_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, m_busy, 0);
    chk({tag, "_done"}, m_done, 0);
    chk({tag, "_in_ready"}, m_in_ready, 0);
    chk({tag, "_wr"}, m_wr, 0);
    chk({tag, "_waddr"}, m_waddr, 0);
    chk({tag, "_wdata"}, m_wdata, 0);
    chk({tag, "_wsel"}, m_wsel, 0);
  endtask

  task automatic set_inst(input int i);
    sel = i;
    gw  = (i == 2) ? 64 : 4;
    gh  = gw;
    gch = (i == 0) ? 1 : 2;
  endtask

  function automatic int px(input int r, input int c, input int k);
    return int'(frame[(r * gw + c) * gch + k]);
  endfunction

  // Reference: every pixel gives a raw write; the pixel closing a 2x2 block
  // is followed by that block's pooled write for the same channel.
  task automatic build_expected(input bit md);
    int v[4];
    int res;
    exp_q.delete();
    for (int r = 0; r < gh; r++)
      for (int c = 0; c < gw; c++)
        for (int k = 0; k < gch; k++) begin
          exp_q.push_back({3'(1 + k), AW'(r * gw + c), (DW + 1)'(px(r, c, k))});
          if ((r % 2 == 1) && (c % 2 == 1)) begin
            v[0] = px(r - 1, c - 1, k);
            v[1] = px(r - 1, c, k);
            v[2] = px(r, c - 1, k);
            v[3] = px(r, c, k);
            if (md) begin
              res = (v[0] + v[1] + v[2] + v[3] + 2) / 4;
            end else begin
              res = v[0];
              for (int i = 1; i < 4; i++) if (v[i] > res) res = v[i];
            end
            exp_q.push_back({3'(1 + gch + k), AW'((r / 2) * (gw / 2) + c / 2),
                             (DW + 1)'(res)});
          end
        end
  endtask

  task automatic run_frame(input bit md, input int gap_pct, input bit mid_start,
                           input int abort_after);
    int n, idx, cycles, dc0, r, c;
    bit v, acc, blk_prev;
    n = gw * gh * gch;
    build_expected(md);
    cap_q.delete();
    dc0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    mode  = md;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0;
    cycles = 0;
    blk_prev = 1'b0;
    while (idx < n && cycles < n * 8 + 64) begin
      v = ($urandom_range(99) >= gap_pct);
      in_valid = v;
      in_data  = frame[idx];
      if (mid_start && idx == n / 2) begin
        start = 1'b1;
        mode  = ~md;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("in_ready_px%0d", idx), m_in_ready, !blk_prev);
      if (mid_start && idx == n / 2) chk("busy_mid_frame", m_busy, 1);
      acc = v && m_in_ready;
      @(posedge clk); #1;
      blk_prev = 1'b0;
      cycles++;
      if (acc) begin
        c = (idx / gch) % gw;
        r = idx / (gch * gw);
        blk_prev = (r % 2 == 1) && (c % 2 == 1);
        idx++;
        if (abort_after > 0 && idx == abort_after) break;
      end
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (abort_after > 0) begin
      reset = 1'b1;
      @(negedge clk);
      check_zero("abort_reset");
      @(posedge clk); #1;
      reset = 1'b0;
      return;
    end
    chk("all_pixels_accepted", idx, n);
    for (int i = 0; i < 40 && done_cnt == dc0; i++) begin
      @(negedge clk); #1;
    end
    chk("done_seen", done_cnt - dc0, 1);
    chk("done_after_last_wr", done_cyc, last_wr_cyc + 1);
    @(negedge clk);
    chk("done_one_cycle", m_done, 0);
    chk("busy_after_done", m_busy, 0);
    chk("wr_count", cap_q.size(), exp_q.size());
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
      chk($sformatf("write%0d", i), cap_q[i], exp_q[i]);
  endtask

  initial begin
    int pv[4];
    int j;
    bit found;
    wr_t last_pool;

    tbl[0] = '{1, 2, 3, 3, 1'b1, 2};
    tbl[1] = '{1, 1, 1, 2, 1'b1, 1};
    tbl[2] = '{2, 2, 2, 2, 1'b1, 2};
    tbl[3] = '{0, 0, 1, 1, 1'b1, 1};
    tbl[4] = '{0, 0, 0, 1, 1'b1, 0};
    tbl[5] = '{1, 2, 3, 3, 1'b0, 3};
    tbl[6] = '{9, 0, 4, 8, 1'b0, 9};
    tbl[7] = '{524287, 524287, 524287, 524287, 1'b1, 524287};

    repeat (3) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sel = i;
      #1;
      check_zero($sformatf("reset_inst%0d", i));
    end
    @(posedge clk); #1;
    reset = 1'b0;

    // 4x4, one channel, ramp 0..15, max pooling
    set_inst(0);
    for (int i = 0; i < 16; i++) frame[i] = DW'(i);
    run_frame(1'b0, 0, 1'b0, 0);
    pv = '{5, 7, 13, 15};
    j = 0;
    foreach (cap_q[i])
      if (cap_q[i].sel == 3'd2 && j < 4) begin
        chk($sformatf("ramp_pool_addr%0d", j), cap_q[i].addr, j);
        chk($sformatf("ramp_pool_data%0d", j), cap_q[i].data, pv[j]);
        j++;
      end
    chk("ramp_pool_count", j, 4);

    // Single-block vectors placed at the top-left block of an otherwise zero frame
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 16; i++) frame[i] = '0;
      frame[0] = DW'(tbl[t].a);
      frame[1] = DW'(tbl[t].b);
      frame[4] = DW'(tbl[t].c);
      frame[5] = DW'(tbl[t].d);
      run_frame(tbl[t].md, 0, 1'b0, 0);
      found = 1'b0;
      foreach (cap_q[i])
        if (!found && cap_q[i].sel == 3'd2 && cap_q[i].addr == '0) begin
          found = 1'b1;
          chk($sformatf("tbl%0d_pool", t), cap_q[i].data, tbl[t].exp);
        end
      chk($sformatf("tbl%0d_pool_seen", t), found, 1);
    end

    // Two interleaved channels, ch0 = v and ch1 = 100 - v
    set_inst(1);
    for (int p = 0; p < 16; p++) begin
      frame[2 * p]     = DW'(p + 1);
      frame[2 * p + 1] = DW'(100 - (p + 1));
    end
    run_frame(1'b0, 0, 1'b0, 0);
    foreach (cap_q[i])
      if (cap_q[i].addr == '0 && cap_q[i].sel == 3'd3) chk("ch0_pool0", cap_q[i].data, 6);
      else if (cap_q[i].addr == '0 && cap_q[i].sel == 3'd4) chk("ch1_pool0", cap_q[i].data, 99);

    // Random pixels with random in_valid gaps and an ignored mid-frame start
    for (int md = 0; md < 2; md++)
      for (int inst = 0; inst < 2; inst++) begin
        set_inst(inst);
        for (int i = 0; i < gw * gh * gch; i++) frame[i] = DW'($urandom_range(0, (1 << DW) - 1));
        run_frame(md[0], 35, 1'b1, 0);
      end

    // Reset after seven accepts, then a clean averaging frame
    set_inst(1);
    for (int i = 0; i < 32; i++) frame[i] = DW'($urandom_range(0, (1 << DW) - 1));
    run_frame(1'b1, 20, 1'b0, 7);
    for (int i = 0; i < 32; i++) frame[i] = DW'($urandom_range(0, (1 << DW) - 1));
    run_frame(1'b1, 0, 1'b0, 0);

    // Full-size frame at full scale, averaging
    set_inst(2);
    for (int i = 0; i < 64 * 64 * 2; i++) frame[i] = {DW{1'b1}};
    run_frame(1'b1, 0, 1'b0, 0);
    found = 1'b0;
    last_pool = '0;
    foreach (cap_q[i])
      if (cap_q[i].sel >= 3'd3) begin
        found = 1'b1;
        last_pool = cap_q[i];
      end
    chk("big_pool_seen", found, 1);
    chk("big_last_pool_addr", last_pool.addr, 1023);
    chk("big_last_pool_data", last_pool.data, (1 << DW) - 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pool_stream_writer.md
Name: pool_stream_writer

Overview:
- Parametrised successor to the fixed 64x64, 2-channel ReLU/max-pool writer stage of the CONV accelerator.
- Accepts a raster-order, channel-interleaved pixel stream from the kernel pipeline through a valid/ready handshake.
- Writes every raw pixel to its layer-0 result bank and every 2x2 pooled result to its layer-1 bank.
- Pooling mode is runtime-selectable: max or rounded average.

Parameters:
- DW, 19: unsigned pixel width (post-ReLU).
- IMG_W, 64: image width; even, >=2.
- IMG_H, 64: image height; even, >=2.
- CH, 2: channel count; 1..3.
- AW, 12: write address width; must satisfy 2^AW >= IMG_W*IMG_H.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle frame start pulse.
- mode  in  1  0 = max, 1 = average; sampled at accepted start.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the last write of the frame.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept a pixel this cycle.
- in_data  in  DW  pixel value.
- wr  out  1  memory write strobe.
- waddr  out  AW  write address.
- wdata  out  DW+1  write data, MSB always 0.
- wsel  out  3  target bank select.

Behaviour:
- Reset (asynchronous, active-high) clears: state IDLE; busy=0, done=0, in_ready=0, wr=0, waddr=0, wdata=0, wsel=0; all counters, hold registers and the partial buffer to 0. Reset mid-frame abandons the frame; no further writes until a new start.
- States:
  - IDLE: start=1 -> latch mode, clear counters, go RUN with busy=1.
  - RUN: normal accept/write operation (below).
  - POOLWR: one cycle in which the pooled write is emitted.
  - FLUSH: last pending write, then pulse done, return to IDLE.
- start while busy is ignored. in_valid in IDLE is ignored (in_ready=0).
- Stream order: for row r in 0..IMG_H-1, column c in 0..IMG_W-1, channel k in 0..CH-1. Counters k -> c -> r wrap in that order.
- Accept condition: in_valid & in_ready. in_ready=1 in RUN, except the cycle immediately after accepting a pixel that completes a 2x2 block (r odd, c odd).
- Raw write, registered, one cycle after accept:
  - wr=1; waddr = r*IMG_W + c; wsel = 1+k; wdata = {0, in_data}.
- Pooled datapath:
  - Per-channel hold register H[k] stores the even-column pixel.
  - Partial buffer P of depth (IMG_W/2)*CH, DW+2 bits per entry.
  - Even row, odd column: P[c/2][k] = combine(H[k], pixel).
  - Odd row, even column: H[k] = combine(P[c/2][k], pixel).
  - Odd row, odd column: result = combine(H[k], pixel).
  - combine: unsigned max in mode 0; sum in mode 1 (no overflow at DW+2 bits).
  - Average output = (sum4 + 2) >> 2, i.e. round half up.
- Pooled write, two cycles after accept of the block-completing pixel (the state POOLWR slot):
  - waddr = (r/2)*(IMG_W/2) + c/2; wsel = 1+CH+k; wdata = {0, result[DW-1:0]}.
  - No raw write collides with it, because in_ready was low the cycle before.
- wr=0 in every cycle with no write due. At most one write per cycle. Writes stay in stream order.
- Frame end: the accept of pixel (IMG_H-1, IMG_W-1, CH-1) leads to its raw write, then the pooled write, then done=1 for one cycle on the following cycle with busy falling together with done.
- Gaps in in_valid are legal anywhere; state is held across them.
- Throughput: per frame, IMG_W*IMG_H*CH accepts plus (IMG_W*IMG_H*CH)/4 stall cycles.

Test Plan:
- IMG_W=IMG_H=4, CH=1, mode 0, pixels 0..15 with no gaps -> 16 raw writes with wsel=1 and waddr=value; pooled writes wsel=2 at addresses 0..3 with data 5, 7, 13, 15; done 1 cycle after last write.
- Same geometry, mode 1, block {1,2,3,3} -> sum 9, pooled wdata 2; block {1,1,1,2} -> sum 5, result 1; block {2,2,2,2} -> 2.
- CH=2, interleaved ch0=v, ch1=100-v -> ch0 raw/pooled on wsel 1/3, ch1 on wsel 2/4; per-channel max values independent and correct.
- Random in_valid gaps plus a start pulse mid-frame -> writes identical to the gap-free run; start ignored; in_ready low exactly after each block-completing accept.
- Reset asserted after 7 accepts -> all outputs 0 next edge; new start and a full frame produce a clean result with no stale partials, checked in mode 1.
- Defaults 64x64, CH=2, all pixels (2^19)-1 -> average equals (2^19)-1 with no overflow; last pooled waddr=1023.
